// File: rtl/icon_tx_arbiter_pkg.sv
// Local definitions for the interconnect tx arbiter: FSM encoding and index helpers.
package icon_tx_arbiter_pkg;
  import pkg_dtypes::*;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  // Next round-robin pointer after index idx among n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/pkg_dtypes.sv
// Shared exec-unit datatypes used across the interconnect.
package pkg_dtypes;
  typedef logic [31:0] type_exec_unit_addr;
  typedef logic [31:0] type_exec_unit_data;
endpackage

// File: rtl/icon_tx_arbiter_if.sv
// Requester and exec-unit tx-port signals shared by the arbiter and its environment.
interface icon_tx_arbiter_if
  import pkg_dtypes::*;
#(
  parameter int unsigned NUM_REQ = 4
);
  logic               [NUM_REQ-1:0] req_valid_i;
  type_exec_unit_addr [NUM_REQ-1:0] req_addr_i;
  logic               [NUM_REQ-1:0] resp_valid_o;
  type_exec_unit_data               resp_data_o;
  logic                             resp_fail_o;
  type_exec_unit_addr               eu_tx_addr_o;
  logic                             eu_tx_req_valid_o;
  logic                             eu_tx_success_i;
  type_exec_unit_data               eu_tx_data_i;

  // Environment side: requesters plus the exec unit.
  modport master (
    output req_valid_i, req_addr_i, eu_tx_success_i, eu_tx_data_i,
    input  resp_valid_o, resp_data_o, resp_fail_o, eu_tx_addr_o, eu_tx_req_valid_o
  );

  // Arbiter side.
  modport slave (
    input  req_valid_i, req_addr_i, eu_tx_success_i, eu_tx_data_i,
    output resp_valid_o, resp_data_o, resp_fail_o, eu_tx_addr_o, eu_tx_req_valid_o
  );
endinterface

// File: rtl/icon_tx_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping.
module rr_priority_picker #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_o,
  output logic                       any_o
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  // ptr_i is always below NUM_REQ, so one conditional subtract performs the wrap.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!any_o && req_i[idx]) begin
        any_o   = 1'b1;
        grant_o = idx;
      end
    end
  end
endmodule

// File: rtl/icon_tx_arbiter.sv
// Round-robin arbiter sharing one exec-unit tx port among NUM_REQ requesters,
// with a per-transaction issue timeout that completes the request as failed.
module icon_tx_arbiter
  import pkg_dtypes::*;
  import icon_tx_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   clk,
  input  logic                   reset_n,
  icon_tx_arbiter_if.slave       bus,
  output logic                   busy_o
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  type_exec_unit_addr addr_q, addr_d;
  type_exec_unit_data data_q, data_d;
  logic               fail_q, fail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_i   (bus.req_valid_i),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_idx),
    .any_o   (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      fail_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      fail_q   <= fail_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fail_d   = fail_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          addr_d  = bus.req_addr_i[pick_idx];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        // Success outranks a timeout landing on the same cycle.
        if (bus.eu_tx_success_i) begin
          data_d  = bus.eu_tx_data_i;
          fail_d  = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q >= CNT_LAST) begin
          data_d  = '0;
          fail_d  = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        rr_ptr_d = IDX_W'(rr_next(int'(grant_q), NUM_REQ));
        cnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [NUM_REQ-1:0] resp_valid;

  always_comb begin
    resp_valid = '0;
    if (state_q == ST_RESP) begin
      resp_valid[grant_q] = 1'b1;
    end
  end

  assign bus.resp_valid_o      = resp_valid;
  assign bus.resp_data_o       = (state_q == ST_RESP) ? data_q : '0;
  assign bus.resp_fail_o       = (state_q == ST_RESP) && fail_q;
  assign bus.eu_tx_req_valid_o = (state_q == ST_ISSUE);
  assign bus.eu_tx_addr_o      = (state_q == ST_ISSUE) ? addr_q : '0;
  assign busy_o                = (state_q != ST_IDLE);
endmodule

// File: tb/tb_icon_tx_arbiter.sv
// Directed bench for icon_tx_arbiter with NUM_REQ=4, TIMEOUT_CYCLES=15.
module tb_icon_tx_arbiter;
  import pkg_dtypes::*;

  logic clk;
  logic reset_n;
  logic busy_o;
  int   tests  = 0;
  int   failed = 0;
  int   n;

  icon_tx_arbiter_if #(.NUM_REQ(4)) bus_if ();

  icon_tx_arbiter #(
    .NUM_REQ        (4),
    .TIMEOUT_CYCLES (15)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if.slave),
    .busy_o  (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_resp_valid"}, 64'(bus_if.resp_valid_o), 64'h0);
    check({tag, "_resp_data"},  64'(bus_if.resp_data_o), 64'h0);
    check({tag, "_resp_fail"},  64'(bus_if.resp_fail_o), 64'h0);
    check({tag, "_eu_valid"},   64'(bus_if.eu_tx_req_valid_o), 64'h0);
    check({tag, "_eu_addr"},    64'(bus_if.eu_tx_addr_o), 64'h0);
    check({tag, "_busy"},       64'(busy_o), 64'h0);
  endtask

  initial begin
    reset_n                = 1'b0;
    bus_if.req_valid_i     = '0;
    bus_if.req_addr_i      = '0;
    bus_if.eu_tx_success_i = 1'b0;
    bus_if.eu_tx_data_i    = '0;
    tick();
    tick();
    check_idle_outputs("reset");
    reset_n = 1'b1;

    // Single request from requester 2, success on first ISSUE cycle.
    bus_if.req_valid_i   = 4'b0100;
    bus_if.req_addr_i[2] = 32'h3;
    check("single_idle_eu_valid", 64'(bus_if.eu_tx_req_valid_o), 64'h0);
    tick();
    check("single_issue_eu_valid", 64'(bus_if.eu_tx_req_valid_o), 64'h1);
    check("single_issue_eu_addr",  64'(bus_if.eu_tx_addr_o), 64'h3);
    check("single_issue_busy",     64'(busy_o), 64'h1);
    check("single_issue_resp",     64'(bus_if.resp_valid_o), 64'h0);
    bus_if.eu_tx_success_i = 1'b1;
    bus_if.eu_tx_data_i    = 32'hAB;
    tick();
    check("single_resp_valid", 64'(bus_if.resp_valid_o), 64'h4);
    check("single_resp_data",  64'(bus_if.resp_data_o), 64'hAB);
    check("single_resp_fail",  64'(bus_if.resp_fail_o), 64'h0);
    check("single_resp_eu",    64'(bus_if.eu_tx_req_valid_o), 64'h0);
    bus_if.eu_tx_success_i = 1'b0;
    bus_if.req_valid_i     = '0;
    tick();
    check("single_after_resp", 64'(bus_if.resp_valid_o), 64'h0);
    check("single_after_busy", 64'(busy_o), 64'h0);

    // All four requesters held, success always: grants 0,1,2,3,0.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) bus_if.req_addr_i[i] = 32'h10 + 32'(i);
    bus_if.req_valid_i     = 4'b1111;
    bus_if.eu_tx_success_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus_if.eu_tx_data_i = 32'hC0 + 32'(k);
      tick();
      check($sformatf("rr%0d_addr", k), 64'(bus_if.eu_tx_addr_o), 64'h10 + 64'(k % 4));
      tick();
      check($sformatf("rr%0d_resp", k), 64'(bus_if.resp_valid_o), 64'h1 << (k % 4));
      check($sformatf("rr%0d_data", k), 64'(bus_if.resp_data_o), 64'hC0 + 64'(k));
      tick();
      check($sformatf("rr%0d_gap", k), 64'(bus_if.resp_valid_o), 64'h0);
    end
    bus_if.req_valid_i     = '0;
    bus_if.eu_tx_success_i = 1'b0;

    // Timeout: success never asserted (rr_ptr is now 1).
    bus_if.req_valid_i  = 4'b0010;
    bus_if.eu_tx_data_i = 32'hFFFF_FFFF;
    tick();
    n = 0;
    while (bus_if.eu_tx_req_valid_o === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    check("timeout_issue_cycles", 64'(n), 64'd15);
    check("timeout_resp_valid",   64'(bus_if.resp_valid_o), 64'h2);
    check("timeout_resp_fail",    64'(bus_if.resp_fail_o), 64'h1);
    check("timeout_resp_data",    64'(bus_if.resp_data_o), 64'h0);
    bus_if.req_valid_i = '0;
    tick();

    // Success on the 15th ISSUE cycle wins over the timeout (rr_ptr is now 2).
    bus_if.req_valid_i  = 4'b0100;
    bus_if.eu_tx_data_i = 32'h5A;
    tick();
    for (int i = 0; i < 14; i++) tick();
    check("late_issue15_eu_valid", 64'(bus_if.eu_tx_req_valid_o), 64'h1);
    bus_if.eu_tx_success_i = 1'b1;
    tick();
    check("late_resp_valid", 64'(bus_if.resp_valid_o), 64'h4);
    check("late_resp_fail",  64'(bus_if.resp_fail_o), 64'h0);
    check("late_resp_data",  64'(bus_if.resp_data_o), 64'h5A);
    bus_if.eu_tx_success_i = 1'b0;
    bus_if.req_valid_i     = '0;
    tick();

    // Requester 2 drops its request mid-ISSUE (rr_ptr is now 3).
    bus_if.req_valid_i   = 4'b0100;
    bus_if.req_addr_i[2] = 32'h22;
    tick();
    bus_if.req_valid_i = '0;
    tick();
    check("drop_issue_addr",  64'(bus_if.eu_tx_addr_o), 64'h22);
    check("drop_issue_valid", 64'(bus_if.eu_tx_req_valid_o), 64'h1);
    bus_if.eu_tx_success_i = 1'b1;
    bus_if.eu_tx_data_i    = 32'h77;
    tick();
    check("drop_resp_valid", 64'(bus_if.resp_valid_o), 64'h4);
    check("drop_resp_data",  64'(bus_if.resp_data_o), 64'h77);
    bus_if.eu_tx_success_i = 1'b0;
    tick();
    check("drop_single_pulse", 64'(bus_if.resp_valid_o), 64'h0);
    check("drop_idle_busy",    64'(busy_o), 64'h0);
    bus_if.req_valid_i = 4'b1111;
    tick();
    check("drop_next_grant3_addr", 64'(bus_if.eu_tx_addr_o), 64'h13);

    // Reset on ISSUE cycle 3 abandons the transaction; arbitration restarts at 0.
    tick();
    tick();
    check("rst_issue3_eu_valid", 64'(bus_if.eu_tx_req_valid_o), 64'h1);
    reset_n            = 1'b0;
    bus_if.req_valid_i = 4'b0011;
    tick();
    check_idle_outputs("rst_mid_issue");
    reset_n = 1'b1;
    tick();
    check("rst_post_grant0_addr", 64'(bus_if.eu_tx_addr_o), 64'h10);
    check("rst_post_no_resp",     64'(bus_if.resp_valid_o), 64'h0);
    bus_if.eu_tx_success_i = 1'b1;
    bus_if.eu_tx_data_i    = 32'h99;
    tick();
    check("rst_post_resp_valid", 64'(bus_if.resp_valid_o), 64'h1);
    check("rst_post_resp_data",  64'(bus_if.resp_data_o), 64'h99);
    bus_if.eu_tx_success_i = 1'b0;
    bus_if.req_valid_i     = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
